// File: rtl/dht11_pkg.sv
// Shared DHT11 timing constants, FSM state encoding and checksum helper.
// Also reused by the host-side sensor interface bench.
package dht11_pkg;

  localparam int unsigned T_START_MIN_US = 18000;
  localparam int unsigned T_WAIT_US      = 30;
  localparam int unsigned T_ACK_US       = 80;
  localparam int unsigned T_BIT_LOW_US   = 50;
  localparam int unsigned T_ZERO_US      = 28;
  localparam int unsigned T_ONE_US       = 70;
  localparam int unsigned T_END_US       = 50;

  localparam int unsigned LowCntW  = 15;
  localparam int unsigned TimerW   = 7;
  localparam int unsigned FrameW   = 40;
  localparam int unsigned BitIdxW  = 6;

  typedef enum logic [2:0] {
    StIdle,
    StHostLow,
    StWaitResp,
    StAckLow,
    StAckHigh,
    StBitLow,
    StBitHigh,
    StEndLow
  } dht11_state_e;

  function automatic logic [7:0] dht11_checksum(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/dht11_responder_if.sv
// Measurement bytes and status signals exchanged between the responder and its user.
interface dht11_responder_if;
  logic [7:0] humidity_int;
  logic [7:0] humidity_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       inject_checksum_error;
  logic       busy;
  logic       frame_done;
  logic       line_drive_low;

  modport master (
    output humidity_int, humidity_dec, temp_int, temp_dec, inject_checksum_error,
    input  busy, frame_done, line_drive_low
  );

  modport slave (
    input  humidity_int, humidity_dec, temp_int, temp_dec, inject_checksum_error,
    output busy, frame_done, line_drive_low
  );
endinterface

// File: rtl/dht11_us_tick.sv
// Divides the system clock by CLK_PER_US into a one-cycle microsecond tick.
module dht11_us_tick #(
  parameter int unsigned CLK_PER_US = 50
) (
  input  logic clock_50Mhz,
  input  logic reset_n,
  output logic tick_o
);

  localparam int unsigned CntW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_PER_US - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CntMax);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dht11_responder.sv
// Sensor end of the DHT11 single-wire protocol (open-drain, 40-bit frame).
// Optional macro DHT11_RESP_ERR_INJECT_EN adds inject_checksum_error to invert the checksum.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 50
) (
  input  logic       clock_50Mhz,
  input  logic       reset_n,
  inout  wire        sensor_data,
  input  logic [7:0] humidity_int,
  input  logic [7:0] humidity_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
`ifdef DHT11_RESP_ERR_INJECT_EN
  input  logic       inject_checksum_error,
`endif
  output logic       busy,
  output logic       frame_done,
  output logic       line_drive_low
);

  logic tick;

  dht11_us_tick #(
    .CLK_PER_US (CLK_PER_US)
  ) u_tick (
    .clock_50Mhz (clock_50Mhz),
    .reset_n     (reset_n),
    .tick_o      (tick)
  );

  dht11_state_e        state_q, state_d;
  logic [1:0]          sync_q, sync_d;
  logic                prev_q, prev_d;
  logic [LowCntW-1:0]  low_cnt_q, low_cnt_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic [BitIdxW-1:0]  bit_idx_q, bit_idx_d;
  logic                drive_q, drive_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                line_fall, line_rise, seg_end;
  logic [TimerW-1:0]   dur;
  logic [7:0]          checksum;

  always_comb begin
    checksum = dht11_checksum(humidity_int, humidity_dec, temp_int, temp_dec);
`ifdef DHT11_RESP_ERR_INJECT_EN
    checksum = checksum ^ {8{inject_checksum_error}};
`endif
  end

  // Edges are taken between the synchronizer output and one further stage.
  always_comb begin
    sync_d    = {sync_q[0], sensor_data};
    prev_d    = sync_q[1];
    line_fall = prev_q & ~sync_q[1];
    line_rise = ~prev_q & sync_q[1];
  end

  always_comb begin
    unique case (state_q)
      StWaitResp:         dur = TimerW'(T_WAIT_US);
      StAckLow, StAckHigh: dur = TimerW'(T_ACK_US);
      StBitLow:           dur = TimerW'(T_BIT_LOW_US);
      StBitHigh:          dur = frame_q[FrameW-1] ? TimerW'(T_ONE_US) : TimerW'(T_ZERO_US);
      StEndLow:           dur = TimerW'(T_END_US);
      default:            dur = TimerW'(1);
    endcase
    seg_end = tick && (timer_q == dur - 1'b1);
  end

  always_comb begin
    state_d   = state_q;
    low_cnt_d = low_cnt_q;
    timer_d   = tick ? timer_q + 1'b1 : timer_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (line_fall) begin
          state_d   = StHostLow;
          low_cnt_d = '0;
        end
      end
      StHostLow: begin
        timer_d = '0;
        if (tick && (low_cnt_q != '1)) begin
          low_cnt_d = low_cnt_q + 1'b1;
        end
        if (line_rise) begin
          if (low_cnt_q >= LowCntW'(T_START_MIN_US)) begin
            state_d   = StWaitResp;
            frame_d   = {humidity_int, humidity_dec, temp_int, temp_dec, checksum};
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWaitResp: if (seg_end) begin
        state_d = StAckLow;
        timer_d = '0;
      end
      StAckLow: if (seg_end) begin
        state_d = StAckHigh;
        timer_d = '0;
      end
      StAckHigh: if (seg_end) begin
        state_d = StBitLow;
        timer_d = '0;
      end
      StBitLow: if (seg_end) begin
        state_d = StBitHigh;
        timer_d = '0;
      end
      StBitHigh: if (seg_end) begin
        timer_d = '0;
        if (bit_idx_q == BitIdxW'(FrameW - 1)) begin
          state_d = StEndLow;
        end else begin
          state_d   = StBitLow;
          frame_d   = {frame_q[FrameW-2:0], 1'b0};
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      StEndLow: if (seg_end) begin
        state_d = StIdle;
        timer_d = '0;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so the pull-down never glitches.
    drive_d = (state_d == StAckLow) || (state_d == StBitLow) || (state_d == StEndLow);
    busy_d  = (state_d != StIdle) && (state_d != StHostLow);
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      sync_q    <= 2'b11;
      prev_q    <= 1'b1;
      low_cnt_q <= '0;
      timer_q   <= '0;
      frame_q   <= '0;
      bit_idx_q <= '0;
      drive_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      low_cnt_q <= low_cnt_d;
      timer_q   <= timer_d;
      frame_q   <= frame_d;
      bit_idx_q <= bit_idx_d;
      drive_q   <= drive_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sensor_data    = drive_q ? 1'b0 : 1'bz;
  assign line_drive_low = drive_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_dht11_responder.sv
// Scoreboard bench: the stimulus pushes expected segment widths (us), a monitor measures them.
// Runs with CLK_PER_US=1 so one cycle equals one microsecond.
module tb_dht11_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic host_low = 1'b0;
  wire  sensor_data;

  always #5 clk = ~clk;

  pullup (sensor_data);
  assign sensor_data = host_low ? 1'b0 : 1'bz;

  dht11_responder_if bus_if ();

  dht11_responder #(
    .CLK_PER_US (1)
  ) dut (
    .clock_50Mhz           (clk),
    .reset_n               (reset_n),
    .sensor_data           (sensor_data),
    .humidity_int          (bus_if.humidity_int),
    .humidity_dec          (bus_if.humidity_dec),
    .temp_int              (bus_if.temp_int),
    .temp_dec              (bus_if.temp_dec),
`ifdef DHT11_RESP_ERR_INJECT_EN
    .inject_checksum_error (bus_if.inject_checksum_error),
`endif
    .busy                  (bus_if.busy),
    .frame_done            (bus_if.frame_done),
    .line_drive_low        (bus_if.line_drive_low)
  );

  int tests = 0;
  int fails = 0;
  int exp_q[$];   // gap width, 1000+low width, or -1 for frame_done at release
  int drive_rises = 0;
  int drive_cycles = 0;
  int done_count = 0;
  int frames_started = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic emit(input int act);
    int  exp;
    bit  ok;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL segment: got %0d, expected nothing", act);
    end else begin
      exp = exp_q.pop_front();
      if (exp < 0 || act < 0) ok = (act == exp);
      else ok = ((act >= 1000) == (exp >= 1000)) && (act - exp <= 1) && (exp - act <= 1);
      if (!ok) begin
        fails++;
        $display("FAIL segment: got %0d, expected %0d", act, exp);
      end
    end
  endtask

  // Monitor: measures released/low run lengths while busy, sampled on the falling clock edge.
  initial begin
    bit in_frame = 1'b0;
    bit level = 1'b0;
    bit drive_prev = 1'b0;
    int run = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_frame = 1'b0;
      end else begin
        if (bus_if.line_drive_low && !drive_prev) drive_rises++;
        if (bus_if.line_drive_low) drive_cycles++;
        if (bus_if.frame_done) done_count++;
        if (bus_if.line_drive_low && sensor_data !== 1'b0) begin
          check("bus_low_when_driven", int'(sensor_data), 0);
        end
        if (!in_frame) begin
          if (bus_if.busy) begin
            in_frame = 1'b1;
            level = bus_if.line_drive_low;
            run = 1;
            frames_started++;
          end
        end else if (bus_if.busy && bus_if.line_drive_low == level) begin
          run++;
        end else begin
          emit(level ? 1000 + run : run);
          if (bus_if.busy) begin
            level = bus_if.line_drive_low;
            run = 1;
          end else begin
            in_frame = 1'b0;
            emit(bus_if.frame_done ? -1 : -2);
          end
        end
      end
      drive_prev = bus_if.line_drive_low;
    end
  end

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] cs, input int nbits,
                            input bit full);
    logic [39:0] f;
    f = {b0, b1, b2, b3, cs};
    exp_q.push_back(30);
    exp_q.push_back(1080);
    exp_q.push_back(80);
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back(1050);
      exp_q.push_back(f[39-i] ? 70 : 28);
    end
    if (full) begin
      exp_q.push_back(1050);
      exp_q.push_back(-1);
    end
  endtask

  task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3);
    bus_if.humidity_int = b0;
    bus_if.humidity_dec = b1;
    bus_if.temp_int     = b2;
    bus_if.temp_dec     = b3;
  endtask

  task automatic host_pulse(input int n);
    @(negedge clk);
    host_low = 1'b1;
    repeat (n) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int base;
    int i;
    base = done_count;
    for (i = 0; i < 8000 && done_count == base; i++) @(negedge clk);
    check(nm, done_count - base, 1);
    repeat (5) @(negedge clk);
    check({nm, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int target;
    int i;
    int dc;
    bus_if.inject_checksum_error = 1'b0;
    set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus_if.busy), 0);
    check("reset_frame_done", int'(bus_if.frame_done), 0);
    check("reset_drive", int'(bus_if.line_drive_low), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Too-short start: no response at all.
    host_pulse(10000);
    repeat (300) @(negedge clk);
    check("short_no_busy", frames_started, 0);
    check("short_no_drive", drive_cycles, 0);

    // Reset during bit 12 (14th pull-down: ACK, bits 0..12).
    set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
    push_frame(8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 12, 1'b0);
    target = drive_rises + 14;
    host_pulse(18100);
    for (i = 0; i < 4000 && drive_rises < target; i++) @(negedge clk);
    check("reach_bit12", drive_rises, target);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_drive_released", int'(bus_if.line_drive_low), 0);
    check("abort_busy", int'(bus_if.busy), 0);
    check("abort_queue", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    dc = done_count;
    repeat (100) @(negedge clk);
    check("abort_no_done", done_count - dc, 0);

    // Full frame after the aborted one.
    push_frame(8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 40, 1'b1);
    host_pulse(18100);
    wait_done("frame_37");

    // All-ones bytes; inputs change and host pulls low during ACK_HIGH.
    set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 40, 1'b1);
    target = drive_rises + 1;
    host_pulse(18100);
    for (i = 0; i < 200 && drive_rises < target; i++) @(negedge clk);
    check("ack_low_seen", drive_rises, target);
    for (i = 0; i < 200 && bus_if.line_drive_low; i++) @(negedge clk);
    check("in_ack_high", int'(bus_if.line_drive_low), 0);
    set_bytes(8'h00, 8'h12, 8'h34, 8'h56);
    host_pulse(20);
    wait_done("frame_ff");

`ifdef DHT11_RESP_ERR_INJECT_EN
    set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
    bus_if.inject_checksum_error = 1'b1;
    push_frame(8'h37, 8'h00, 8'h19, 8'h05, 8'hAA, 40, 1'b1);
    host_pulse(18100);
    bus_if.inject_checksum_error = 1'b0;
    wait_done("frame_inject");
    check("total_frames", done_count, 3);
`else
    check("total_frames", done_count, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
